// File: rtl/ddr_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_video_pkg
// Description : Shared 640x480 video timing constants and the sync decoder
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_video_pkg;

  // Decoder lock state: hunting for a frame boundary, qualifying frames, locked
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  // 640x480 @ 60 Hz timing
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;

endpackage
`default_nettype wire

// File: rtl/sync_decoder_480p_sig_edge.sv
`default_nettype none
// ============================================================================
// Module      : sig_edge
// Description : Single-bit input register with registered rise/fall strobes.
//               Strobes are aligned with the registered copy of the signal.
// Revision    : 1.0 - initial release
// ============================================================================
module sig_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic sig_o,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;
  logic rise_q;
  logic fall_q;

  // Capture the input and compare it against the previous captured value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      rise_q <= sig_i & ~sig_q;
      fall_q <= ~sig_i & sig_q;
    end
  end

  assign sig_o  = sig_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/sync_decoder_480p.sv
`default_nettype none
// ============================================================================
// Module      : sync_decoder_480p
// Description : Reconstructs sx/sy from a raw hsync/vsync/de stream, measures
//               active width/height and locks once the stream matches the
//               expected resolution for LOCK_FRAMES consecutive frames.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_decoder_480p #(
  parameter int CORDW       = 10,
  parameter int H_RES       = ddr_video_pkg::H_RES,
  parameter int V_RES       = ddr_video_pkg::V_RES,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             pix_valid,
  output logic             line_o,
  output logic             frame_o,
  output logic             locked,
  output logic             err
);

  import ddr_video_pkg::*;

  localparam logic [CORDW-1:0] CNT_MAX  = '1;
  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] V_EXP    = CORDW'(V_RES);
  localparam logic [2:0]       GOOD_TGT = 3'(LOCK_FRAMES);
  localparam logic             SYNC_INV = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  // ---------------------------------------------------------------- stage 1
  logic hs_q, hs_rise, hs_fall;
  logic vs_q, vs_rise, vs_fall;
  logic de_q, de_rise, de_fall;

  sig_edge u_hs_edge (
    .clk_i (clk_pix),
    .rst_ni(rst_pix_n),
    .sig_i (hsync ^ SYNC_INV),
    .sig_o (hs_q),
    .rise_o(hs_rise),
    .fall_o(hs_fall)
  );

  sig_edge u_vs_edge (
    .clk_i (clk_pix),
    .rst_ni(rst_pix_n),
    .sig_i (vsync ^ SYNC_INV),
    .sig_o (vs_q),
    .rise_o(vs_rise),
    .fall_o(vs_fall)
  );

  sig_edge u_de_edge (
    .clk_i (clk_pix),
    .rst_ni(rst_pix_n),
    .sig_i (de),
    .sig_o (de_q),
    .rise_o(de_rise),
    .fall_o(de_fall)
  );

  // hsync is registered for symmetry but coordinates are derived from de alone
  logic unused_sig;
  assign unused_sig = ^{hs_q, hs_rise, hs_fall, vs_fall,
                        16'(H_TOTAL), 16'(V_TOTAL)};

  // ---------------------------------------------------------------- counters
  logic [CORDW-1:0] pix_cnt_q, pix_cnt_d;
  logic [CORDW-1:0] line_cnt_q, line_cnt_d, line_upd;
  logic             pix_sat_q, pix_sat_d;
  logic             line_sat_q, line_sat_d, line_sat_upd;
  logic             bad_q, bad_d;
  logic             width_bad, height_bad, de_in_vs, any_bad;

  // Pixel/line counting, width/height checks and the per-frame bad flag
  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    pix_sat_d    = pix_sat_q;
    line_upd     = line_cnt_q;
    line_sat_upd = line_sat_q;

    if (de_rise) begin
      pix_cnt_d = '0;
      pix_sat_d = 1'b0;
    end else if (de_q) begin
      if (pix_cnt_q == CNT_MAX) pix_sat_d = 1'b1;
      else                      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    // pix_cnt_q holds the index of the last active pixel, so width = index+1
    width_bad = de_fall && (pix_sat_q || (pix_cnt_q != H_LAST));

    // A line ending in the same cycle as vsync is counted before the height check
    if (de_fall) begin
      if (line_cnt_q == CNT_MAX) line_sat_upd = 1'b1;
      else                       line_upd     = line_cnt_q + 1'b1;
    end

    height_bad = vs_rise && (line_sat_upd || (line_upd != V_EXP));
    de_in_vs   = de_q && vs_q;
    any_bad    = width_bad || height_bad || de_in_vs;

    line_cnt_d = vs_rise ? '0   : line_upd;
    line_sat_d = vs_rise ? 1'b0 : line_sat_upd;
    bad_d      = vs_rise ? 1'b0 : (bad_q || any_bad);
  end

  // Counter and frame-flag registers
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      pix_cnt_q  <= '0;
      pix_sat_q  <= 1'b0;
      line_cnt_q <= '0;
      line_sat_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      pix_sat_q  <= pix_sat_d;
      line_cnt_q <= line_cnt_d;
      line_sat_q <= line_sat_d;
      bad_q      <= bad_d;
    end
  end

  // ---------------------------------------------------------------- FSM
  sync_state_t state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic        err_d;

  // Lock state register
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Next lock state: qualify whole frames, drop lock on the first violation
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = TRAIN;
          good_d  = '0;
        end
      end
      TRAIN: begin
        if (vs_rise) begin
          if (bad_q || any_bad) begin
            good_d = '0;
          end else begin
            good_d = good_q + 3'd1;
            if ((good_q + 3'd1) == GOOD_TGT) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (any_bad) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic             pix_valid_q, pix_valid_d;
  logic             line_q, line_d, frame_q, frame_d, err_q;
  logic             lock_next;

  // Output strobes follow the post-update state so they line up with locked
  always_comb begin
    lock_next   = (state_d == LOCKED);
    pix_valid_d = de_q && lock_next;
    line_d      = de_fall && lock_next;
    frame_d     = vs_rise && lock_next;
    sx_d        = pix_valid_d ? pix_cnt_d  : sx_q;
    sy_d        = pix_valid_d ? line_cnt_d : sy_q;
  end

  // Output register stage
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      pix_valid_q <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      pix_valid_q <= pix_valid_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
    end
  end

  assign sx        = sx_q;
  assign sy        = sy_q;
  assign pix_valid = pix_valid_q;
  assign line_o    = line_q;
  assign frame_o   = frame_q;
  assign err       = err_q;
  assign locked    = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_sync_decoder_480p.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_decoder_480p
// Description : Scoreboard bench for sync_decoder_480p. A reduced-size video
//               raster drives two decoders (negative and positive syncs); a
//               frame-level reference model predicts every output strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_decoder_480p;

  // Scaled-down raster so many frames fit in a short run
  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VA = 12, VFP = 2, VSW = 2, VBP = 2;
  localparam int LOCK_N = 2;

  typedef struct {
    int ts;
    bit pv;
    int sx;
    int sy;
    bit ln;
    bit fr;
    bit er;
  } ev_t;

  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b0;
  logic de = 1'b0, hs_act = 1'b0, vs_act = 1'b0;

  logic [9:0] sx0, sy0, sx1, sy1;
  logic pv0, ln0, fr0, lk0, er0;
  logic pv1, ln1, fr1, lk1, er1;

  always #5 clk_pix = ~clk_pix;

  sync_decoder_480p #(.CORDW(10), .H_RES(HA), .V_RES(VA), .SYNC_POL(0), .LOCK_FRAMES(LOCK_N)) u_dut_neg (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(~hs_act), .vsync(~vs_act), .de(de),
    .sx(sx0), .sy(sy0), .pix_valid(pv0), .line_o(ln0), .frame_o(fr0), .locked(lk0), .err(er0));

  sync_decoder_480p #(.CORDW(10), .H_RES(HA), .V_RES(VA), .SYNC_POL(1), .LOCK_FRAMES(LOCK_N)) u_dut_pos (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(hs_act), .vsync(vs_act), .de(de),
    .sx(sx1), .sy(sy1), .pix_valid(pv1), .line_o(ln1), .frame_o(fr1), .locked(lk1), .err(er1));

  int  pcyc = 0;
  int  n_chk = 0, n_pass = 0;
  int  drv_n = 0, rst_from = 0, rst_to = 4;
  ev_t evq[$];
  int  rd[2] = '{0, 0};
  bit  exp_lock[int];

  always @(posedge clk_pix) pcyc <= pcyc + 1;

  task automatic chk(input bit ok, input string name, input string act, input string exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  // ------------------------------------------------------- reference model
  // Tracks the stream in terms of line widths, line counts and good frames.
  bit m_prev_de, m_prev_vs, m_bad;
  int m_width, m_lines, m_mode, m_good;   // mode: 0 search, 1 train, 2 locked

  task automatic model_reset(input int now);
    m_prev_de = 0; m_prev_vs = 0; m_bad = 0;
    m_width = 0; m_lines = 0; m_mode = 0; m_good = 0;
    exp_lock[now + 1] = 0;
    exp_lock[now + 2] = 0;
    rd[0] = evq.size();
    rd[1] = evq.size();
  endtask

  task automatic model_step(input bit d, input bit v, input int now);
    bit rise, fall, vr, mw, mh, mdv, frame_bad, er, lk;
    ev_t e;
    rise = d && !m_prev_de;
    fall = !d && m_prev_de;
    vr   = v && !m_prev_vs;
    if (rise) m_width = 1;
    else if (d) m_width++;
    mw = fall && (m_width != HA);
    if (fall) m_lines++;
    mh  = vr && (m_lines != VA);
    mdv = d && v;
    frame_bad = m_bad || mw || mh || mdv;
    er = 0;
    if (m_mode == 0) begin
      if (vr) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      if (vr) begin
        if (frame_bad) m_good = 0;
        else begin
          m_good++;
          if (m_good == LOCK_N) m_mode = 2;
        end
      end
    end else if (mw || mh || mdv) begin
      er = 1; m_mode = 0;
    end
    lk = (m_mode == 2);
    e.ts = now + 2; e.pv = lk && d; e.sx = m_width - 1; e.sy = m_lines;
    e.ln = lk && fall; e.fr = lk && vr; e.er = er;
    if (e.pv || e.ln || e.fr || e.er) evq.push_back(e);
    exp_lock[now + 2] = lk;
    m_bad = vr ? 1'b0 : frame_bad;
    if (vr) m_lines = 0;
    m_prev_de = d;
    m_prev_vs = v;
  endtask

  // ------------------------------------------------------- stimulus
  task automatic drive(input bit d, input bit h, input bit v);
    @(negedge clk_pix);
    rst_pix_n = !(drv_n >= rst_from && drv_n < rst_to);
    de = d; hs_act = h; vs_act = v;
    if (!rst_pix_n) model_reset(pcyc);
    else model_step(d, v, pcyc);
    drv_n++;
  endtask

  // One frame; optional faults: odd-width line, wrong line count, de inside
  // vsync, or vsync rising in the same cycle the last active line ends.
  task automatic gen_frame(input int nact, input int bad_line, input int bad_w,
                           input bit dv, input bit coinc);
    int vt, vs_start, vs_end, t, w;
    bit dd, hh, vv;
    vt       = nact + VFP + VSW + VBP;
    vs_start = coinc ? ((nact - 1) * HT + HA) : ((nact + VFP) * HT);
    vs_end   = vs_start + VSW * HT;
    for (int l = 0; l < vt; l++) begin
      for (int c = 0; c < HT; c++) begin
        t  = l * HT + c;
        w  = (l == bad_line) ? bad_w : HA;
        dd = (l < nact && c < w) || (dv && l == nact + VFP && c < 4);
        hh = (c >= HA + HFP) && (c < HA + HFP + HSW);
        vv = (t >= vs_start) && (t < vs_end);
        drive(dd, hh, vv);
      end
    end
  endtask

  task automatic clean_frames(input int n);
    for (int i = 0; i < n; i++) gen_frame(VA, -1, 0, 1'b0, 1'b0);
  endtask

  // ------------------------------------------------------- monitor
  task automatic check_dut(input int id, input int now, input logic pv,
                           input logic [9:0] sx, input logic [9:0] sy,
                           input logic ln, input logic fr, input logic er, input logic lk);
    string a;
    ev_t e;
    a = $sformatf("t=%0d pv=%0b sx=%0d sy=%0d line=%0b frame=%0b err=%0b",
                  now, pv, sx, sy, ln, fr, er);
    while (rd[id] < evq.size() && evq[rd[id]].ts < now) begin
      chk(1'b0, $sformatf("dut%0d_missed", id), "nothing",
          $sformatf("event at t=%0d", evq[rd[id]].ts));
      rd[id]++;
    end
    if (rd[id] < evq.size() && evq[rd[id]].ts == now) begin
      e = evq[rd[id]];
      rd[id]++;
      chk(pv == e.pv && ln == e.ln && fr == e.fr && er == e.er &&
          (!e.pv || (int'(sx) == e.sx && int'(sy) == e.sy)),
          $sformatf("dut%0d_event", id), a,
          $sformatf("pv=%0b sx=%0d sy=%0d line=%0b frame=%0b err=%0b",
                    e.pv, e.sx, e.sy, e.ln, e.fr, e.er));
    end else if (pv || ln || fr || er) begin
      chk(1'b0, $sformatf("dut%0d_unexpected", id), a, "no strobe");
    end
    if (exp_lock.exists(now))
      chk(lk == exp_lock[now], $sformatf("dut%0d_locked", id),
          $sformatf("%0b at t=%0d", lk, now), $sformatf("%0b", exp_lock[now]));
    if (!rst_pix_n)
      chk(!pv && !ln && !fr && !er && !lk && sx == 0 && sy == 0,
          $sformatf("dut%0d_reset_outputs", id), a, "all zero");
  endtask

  always @(posedge clk_pix) begin
    #3;
    check_dut(0, pcyc, pv0, sx0, sy0, ln0, fr0, er0, lk0);
    check_dut(1, pcyc, pv1, sx1, sy1, ln1, fr1, er1, lk1);
    if (exp_lock.exists(pcyc)) exp_lock.delete(pcyc);
  end

  // ------------------------------------------------------- test sequence
  initial begin
    int kind;
    repeat (8) drive(1'b0, 1'b0, 1'b0);

    // Lock after three clean frames, then stay locked
    clean_frames(4);
    // Short line while locked: err, then relock
    gen_frame(VA, 5, HA - 1, 1'b0, 1'b0);
    clean_frames(4);
    // Extra active line during training delays lock by one frame
    rst_from = drv_n + 10; rst_to = rst_from + 3;
    clean_frames(1);
    gen_frame(VA + 1, -1, 0, 1'b0, 1'b0);
    clean_frames(4);
    // Line end and vsync in the same cycle while locked
    gen_frame(VA, -1, 0, 1'b0, 1'b1);
    clean_frames(1);
    // Reset in the middle of an active line while locked
    rst_from = drv_n + 3 * HT + 5; rst_to = rst_from + 3;
    clean_frames(4);
    // de during vsync while locked
    gen_frame(VA, -1, 0, 1'b1, 1'b0);
    clean_frames(3);

    // Randomised mix of clean and faulty frames
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        5: gen_frame(VA, $urandom_range(0, VA - 1),
                     ($urandom_range(0, 1) == 1) ? HA + 1 : HA - 1, 1'b0, 1'b0);
        6: gen_frame(($urandom_range(0, 1) == 1) ? VA + 1 : VA - 1, -1, 0, 1'b0, 1'b0);
        7: gen_frame(VA, -1, 0, 1'b1, 1'b0);
        8: gen_frame(VA, -1, 0, 1'b0, 1'b1);
        9: begin
          rst_from = drv_n + $urandom_range(1, 400);
          rst_to   = rst_from + $urandom_range(1, 4);
          clean_frames(1);
        end
        default: clean_frames(1);
      endcase
    end

    repeat (6) drive(1'b0, 1'b0, 1'b0);
    @(posedge clk_pix);
    #4;
    chk(rd[0] == evq.size(), "dut0_drain", $sformatf("%0d consumed", rd[0]),
        $sformatf("%0d", evq.size()));
    chk(rd[1] == evq.size(), "dut1_drain", $sformatf("%0d consumed", rd[1]),
        $sformatf("%0d", evq.size()));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_decoder_480p.md
# sync_decoder_480p

Receive-side counterpart of the 640x480 display timing generator. Consumes a raw hsync/vsync/de stream in the pixel clock domain and reconstructs pixel coordinates. It also measures active width and height, and declares lock once the stream matches the expected resolution. Sits between the video input pins (or a loopback of the DVI output) and any logic that needs sx/sy for incoming video, such as a capture, checker or overlay stage in the DDR game.

## Interface
Parameters:
- CORDW, 10, coordinate width in bits
- H_RES, 640, expected active pixels per line
- V_RES, 480, expected active lines per frame
- SYNC_POL, 0, sync polarity: 0 = active-low hsync/vsync, 1 = active-high
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..7)

Ports:
- clk_pix  in  1  pixel clock; the only clock
- rst_pix_n  in  1  reset, asynchronous assert, active-low
- hsync  in  1  horizontal sync, polarity per SYNC_POL
- vsync  in  1  vertical sync, polarity per SYNC_POL
- de  in  1  data enable, active-high
- sx  out  CORDW  pixel column, valid while pix_valid
- sy  out  CORDW  pixel row, valid while pix_valid
- pix_valid  out  1  active pixel present and decoder locked
- line_o  out  1  one-cycle pulse at end of each active line while locked
- frame_o  out  1  one-cycle pulse at each vsync active edge while locked
- locked  out  1  stream matches H_RES x V_RES
- err  out  1  one-cycle pulse on timing violation while locked

## Operation
- Stage 1 registers hsync, vsync and de, and normalises sync to active-high using SYNC_POL. Edges are detected against the stage-1 copy: de_rise, de_fall, vs_rise.
- Pixel counter:
  - Clears to 0 on de_rise and increments each de-high cycle.
  - Saturates at 2^CORDW-1; saturation counts as a width mismatch.
  - At de_fall, the final count (the line width) is compared with H_RES.
- Line counter:
  - Increments on each de_fall and clears to 0 on vs_rise. Saturates like the pixel counter.
  - At vs_rise, the count is compared with V_RES.
- Per-frame flag `bad` sets on any width mismatch, height mismatch, or de high while vsync is active. It clears at vs_rise after evaluation.
- FSM states:
  - SEARCH: locked=0. Exits to TRAIN on vs_rise, which clears good_cnt.
  - TRAIN: locked=0. At vs_rise, a clean frame increments good_cnt and a bad one clears it. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked=1. Any mismatch (at de_fall, at vs_rise, or de during vsync) pulses err and returns to SEARCH.
- If de_fall and vs_rise occur in the same cycle, the line is counted and checked first, then the frame check uses the updated line count.
- Outputs when not LOCKED: pix_valid, line_o and frame_o are 0. sx and sy hold their last value.

## Timing
- Reset (async): all outputs 0, FSM in SEARCH, all counters 0. After release, a full SEARCH then TRAIN sequence is needed to relock.
- Latency: sx, sy and pix_valid appear 2 cycles after the corresponding de sample (input register plus output register). line_o, frame_o and err have the same 2-cycle latency from the causing edge.
- Lock timing:
  - locked rises 2 cycles after the vs_rise that completes training. That is the (LOCK_FRAMES+1)-th vs_rise after reset.
  - frame_o also pulses on that edge.
- Loss of lock: locked falls in the same cycle err pulses.
- Reset asserted mid-line: outputs clear immediately. Partial-frame counts are discarded.

## Structure
- Package ddr_video_pkg holds:
  - typedef enum {SEARCH, TRAIN, LOCKED} sync_state_t
  - 480p constants: H_RES=640, V_RES=480, H_TOTAL=800, V_TOTAL=525
- One sub-module, sig_edge: a single-bit input register plus rise/fall strobe. Instantiate it three times.

## Test plan
All scenarios use standard 640x480 timing: 800x525 total, negative syncs, SYNC_POL=0.
- Reset, then 3 clean frames -> locked=1 and frame_o pulse 2 cycles after the 3rd vs_rise; err never pulses.
- Locked, first active pixel -> sx=0, sy=0, pix_valid=1 two cycles after de rises. Last pixel of frame -> sx=639, sy=479. line_o pulses 480 times per frame.
- Locked, one line shortened to 639 de cycles -> err pulse and locked=0 two cycles after that de_fall. Relock after 3 further vs_rise.
- In TRAIN, one frame with 481 active lines -> good_cnt clears; lock is delayed by exactly one frame.
- Async reset mid-line while locked -> all outputs 0 immediately, no err pulse. Relock on the 3rd vs_rise after release.
- SYNC_POL=1 with inverted syncs -> behaviour identical to the first scenario.
